// File: rtl/jt12_slot_regq.sv
// Rotating operator/channel slot sequencer with a per-slot register store.
// CPU writes are queued and each one is applied only when its target slot
// comes round. This keeps the pipeline running while the CPU writes.
module jt12_slot_regq #(
    parameter int NUM_CH = 6,
    parameter int DW     = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     wr_all,
    input  logic [2:0]               wr_ch,
    input  logic [1:0]               wr_op,
    input  logic [DW-1:0]            wr_data,
    output logic [2:0]               cur_ch,
    output logic [1:0]               cur_op,
    output logic                     zero,
    output logic [DW-1:0]            slot_data,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     drop
);

    localparam int N  = 4 * NUM_CH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(N);
    localparam logic [3:0]    NUM_CH_W = 4'(NUM_CH);
    localparam logic [2:0]    LAST_IDX = 3'(NUM_CH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST_BC  = CW'(N - 1);

    typedef struct packed {
        logic          all;
        logic [2:0]    ch;
        logic [1:0]    op;
        logic [DW-1:0] data;
    } wr_entry_t;

    // Slot position: channel index (dense, 0..NUM_CH-1) and operator
    logic [2:0]    r_ch_idx;
    logic [1:0]    r_op;
    logic [DW-1:0] r_store [N];
    wr_entry_t     r_fifo  [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [CW-1:0] r_bc_cnt;
    logic          r_drop;

    logic          w_last_ch;
    logic [2:0]    w_nxt_ch_idx;
    logic [1:0]    w_nxt_op;
    logic          w_push;
    logic          w_empty;
    wr_entry_t     w_head;
    logic          w_head_valid;
    logic [2:0]    w_head_idx;
    logic          w_wr_slot;
    logic          w_pop;
    logic          w_drop;
    logic [CW-1:0] w_bc_cnt_nxt;

    // Next slot in rotation order: channels first, then operator
    assign w_last_ch    = (r_ch_idx == LAST_IDX);
    assign w_nxt_ch_idx = w_last_ch ? 3'd0 : r_ch_idx + 3'd1;
    assign w_nxt_op     = w_last_ch ? r_op + 2'd1 : r_op;

    // With six channels the codes skip 3, so index 3..5 map to codes 4..6
    assign cur_ch    = (NUM_CH == 6 && r_ch_idx >= 3'd3) ? r_ch_idx + 3'd1 : r_ch_idx;
    assign cur_op    = r_op;
    assign zero      = (r_op == 2'd0) && (r_ch_idx == 3'd0);
    assign slot_data = r_store[0];

    assign pending  = r_wptr - r_rptr;
    assign w_empty  = (pending == '0);
    assign wr_ready = (pending != FULL_CNT);
    assign w_push   = wr_valid && wr_ready;
    assign drop     = r_drop;

    // Head decode: codes 3 and 7 are holes in the six-channel map
    assign w_head       = r_fifo[r_rptr[AW-1:0]];
    assign w_head_valid = (NUM_CH == 6) ? (w_head.ch[1:0] != 2'b11)
                                        : ({1'b0, w_head.ch} < NUM_CH_W);
    assign w_head_idx   = (NUM_CH == 6 && w_head.ch > 3'd3) ? w_head.ch - 3'd1 : w_head.ch;

    // Decide whether the FIFO head writes the incoming slot and/or is popped
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        w_wr_slot    = 1'b0;
        w_pop        = 1'b0;
        w_drop       = 1'b0;
        w_bc_cnt_nxt = r_bc_cnt;
        if (clk_en && !w_empty) begin
            if (w_head.all) begin
                w_wr_slot = 1'b1;
                if (r_bc_cnt == LAST_BC) begin
                    w_pop        = 1'b1;
                    w_bc_cnt_nxt = '0;
                end else begin
                    w_bc_cnt_nxt = r_bc_cnt + 1'b1;
                end
            end else if (!w_head_valid) begin
                w_pop  = 1'b1;
                w_drop = 1'b1;
            end else if (w_head_idx == w_nxt_ch_idx && w_head.op == w_nxt_op) begin
                w_wr_slot = 1'b1;
                w_pop     = 1'b1;
            end
        end
    end

    // Slot counter, broadcast progress and drop pulse
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch_idx <= '0;
            r_op     <= '0;
            r_bc_cnt <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_bc_cnt <= w_bc_cnt_nxt;
            r_drop   <= w_drop;
            if (clk_en) begin
                r_ch_idx <= w_nxt_ch_idx;
                r_op     <= w_nxt_op;
            end
        end
    end

    // Register store rotates one slot per clk_en; entry 0 is the current slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_store[i] <= '0;
        end else if (clk_en) begin
            r_store[0] <= w_wr_slot ? w_head.data : r_store[1];
            for (int i = 1; i < N - 1; i++) r_store[i] <= r_store[i + 1];
            r_store[N - 1] <= r_store[0];
        end
    end

    // FIFO pointers: push ignores clk_en, pop follows the apply decision
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // FIFO storage
    // NOTE: entries are not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr[AW-1:0]] <= '{all: wr_all, ch: wr_ch, op: wr_op, data: wr_data};
    end

endmodule

// File: tb/tb_jt12_slot_regq.sv
// Directed bench for jt12_slot_regq with NUM_CH=6, DW=8, DEPTH=4.
module tb_jt12_slot_regq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       wr_all = 1'b0;
    logic [2:0] wr_ch = '0;
    logic [1:0] wr_op = '0;
    logic [7:0] wr_data = '0;
    logic [2:0] cur_ch;
    logic [1:0] cur_op;
    logic       zero;
    logic [7:0] slot_data;
    logic [2:0] pending;
    logic       drop;

    int n_checks = 0;
    int n_errors = 0;
    int pos = 0;
    int ch_tab [6] = '{0, 1, 2, 4, 5, 6};

    jt12_slot_regq #(.NUM_CH(6), .DW(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_all(wr_all),
        .wr_ch(wr_ch), .wr_op(wr_op), .wr_data(wr_data),
        .cur_ch(cur_ch), .cur_op(cur_op), .zero(zero),
        .slot_data(slot_data), .pending(pending), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        pos = (pos + 1) % 24;
    endtask

    task automatic push(input logic all, input logic [2:0] ch, input logic [1:0] op,
                        input logic [7:0] d);
        wr_valid = 1'b1;
        wr_all   = all;
        wr_ch    = ch;
        wr_op    = op;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        wr_all   = 1'b0;
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_op"}, cur_op, pos / 6);
        check({tag, "_ch"}, cur_ch, ch_tab[pos % 6]);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_pos("rst");
        check("rst_zero", zero, 1);
        check("rst_data", slot_data, 0);
        check("rst_pending", pending, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_drop", drop, 0);

        // One full revolution of an empty store
        for (int i = 0; i < 24; i++) begin
            step();
            check_pos("seq");
            check("seq_zero", zero, (pos == 0) ? 1 : 0);
            check("seq_data", slot_data, 0);
        end

        // Targeted write accepted one slot early
        step();
        push(1'b0, 3'd2, 2'd0, 8'h5A);
        check_pos("hold");
        check("t1_pending", pending, 1);
        step();
        check_pos("t1_at");
        check("t1_data", slot_data, 8'h5A);
        check("t1_pending0", pending, 0);
        for (int i = 0; i < 23; i++) step();
        check("t1_prev", slot_data, 0);
        step();
        check("t1_rev2", slot_data, 8'h5A);

        // Strict order: op1/ch0 first, op0/ch1 a revolution later
        step();
        check_pos("t2_start");
        push(1'b0, 3'd0, 2'd1, 8'h11);
        push(1'b0, 3'd1, 2'd0, 8'h22);
        check("t2_pending2", pending, 2);
        for (int i = 0; i < 3; i++) step();
        check_pos("t2_a");
        check("t2_a_data", slot_data, 8'h11);
        check("t2_a_pending", pending, 1);
        for (int i = 0; i < 19; i++) step();
        check_pos("t2_b");
        check("t2_b_data", slot_data, 8'h22);
        check("t2_b_pending", pending, 0);

        // Fill the FIFO with clk_en low, then drain it
        push(1'b0, 3'd4, 2'd0, 8'h31);
        push(1'b0, 3'd5, 2'd0, 8'h32);
        push(1'b0, 3'd6, 2'd0, 8'h33);
        push(1'b0, 3'd0, 2'd1, 8'h34);
        check("full_ready", wr_ready, 0);
        check("full_pending", pending, 4);
        push(1'b0, 3'd0, 2'd2, 8'h99);
        check("full_reject", pending, 4);
        step();
        check("full_wait_data", slot_data, 8'h5A);
        check("full_wait_pending", pending, 4);
        step();
        check("drain_0", slot_data, 8'h31);
        check("drain_ready", wr_ready, 1);
        check("drain_pending", pending, 3);
        step();
        check("drain_1", slot_data, 8'h32);
        step();
        check("drain_2", slot_data, 8'h33);
        step();
        check("drain_3", slot_data, 8'h34);
        check("drain_empty", pending, 0);
        for (int i = 0; i < 6; i++) step();
        check_pos("reject_slot");
        check("reject_data", slot_data, 0);

        // Broadcast followed by a targeted write to op2/ch0
        push(1'b1, 3'd0, 2'd0, 8'hFF);
        push(1'b0, 3'd0, 2'd2, 8'h01);
        check("bc_pending", pending, 2);
        for (int i = 0; i < 24; i++) begin
            step();
            check("bc_rev1", slot_data, 8'hFF);
        end
        check("bc_done_pending", pending, 1);
        for (int i = 0; i < 24; i++) begin
            step();
            check("bc_rev2", slot_data, (pos == 12) ? 8'h01 : 8'hFF);
        end
        check("bc_tgt_pending", pending, 0);

        // Invalid channel code 3 is discarded
        push(1'b0, 3'd3, 2'd0, 8'h77);
        check("drop_idle", drop, 0);
        step();
        check("drop_pulse", drop, 1);
        check("drop_pending", pending, 0);
        check("drop_data", slot_data, 8'hFF);
        tick();
        check("drop_end", drop, 0);
        check("drop_hold", slot_data, 8'hFF);

        // Reset in the middle of a broadcast
        push(1'b1, 3'd0, 2'd0, 8'h42);
        for (int i = 0; i < 5; i++) step();
        check("mid_bc_data", slot_data, 8'h42);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pos = 0;
        check_pos("rst2");
        check("rst2_pending", pending, 0);
        check("rst2_data", slot_data, 0);
        for (int i = 0; i < 24; i++) begin
            step();
            check("rst2_store", slot_data, 0);
        end
        check("rst2_pending_end", pending, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
